mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM pipeline register; consumes its EM_* outputs.
- Drives the data-memory request/acknowledge handshake, which has variable latency.
- Stalls the upstream pipeline while an access is outstanding.
- Registers the write-back bundle (MW_RegWrite, MW_WBAddr, MW_WBData). MW_WBData also feeds the EX/MEM store-data forwarding path.

Parameters:
- TIMEOUT_CYCLES, 255: maximum number of BUSY cycles before an access is abandoned. Used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  single clock; rising edge
- rst  input  1  synchronous, active-high reset
- EM_MemRead  input  1  load in the EX/MEM slot
- EM_MemWrite  input  1  store in the EX/MEM slot
- EM_RegWrite  input  1  instruction writes the register file
- EM_MemtoReg  input  1  write-back data comes from memory
- EM_RegDst  input  2  2'h2 = link (jal); write-back data = EM_PCPlus4
- EM_WBAddr  input  5  destination register
- EM_ALUResult  input  32  address or ALU value
- EM_WriteData  input  32  store data
- EM_PCPlus4  input  32  link value
- dm_req  output  1  memory request; held until dm_ack
- dm_we  output  1  1 = write
- dm_addr  output  32  word-aligned address
- dm_wdata  output  32  store data
- dm_ack  input  1  one-cycle completion pulse
- dm_rdata  input  32  load data; valid while dm_ack = 1
- MEM_Stall  output  1  freeze PC/IF/ID/EX/EX_MEM this cycle
- MW_RegWrite  output  1  write-back enable
- MW_WBAddr  output  5  write-back register
- MW_WBData  output  32  write-back data
- MEM_Err  output  1  sticky timeout flag

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0. rst takes priority over every other input, including when asserted mid-BUSY.
- An access is pending when (EM_MemRead | EM_MemWrite) = 1. If both are set, the access is a write and no load data is returned.
- IDLE state:
  - Access pending: MEM_Stall = 1 (combinational). Next edge: state BUSY; dm_req <= 1; dm_we <= EM_MemWrite; dm_addr <= {EM_ALUResult[31:2], 2'b00}; dm_wdata <= EM_WriteData. MW_RegWrite <= 0 (bubble).
  - No access pending: MEM_Stall = 0. MW registers load the current EM instruction every cycle.
- BUSY state:
  - dm_req, dm_we, dm_addr and dm_wdata stay stable.
  - dm_ack = 0: MEM_Stall = 1; MW_RegWrite <= 0.
  - dm_ack = 1: MEM_Stall = 0 in the same cycle, so EM advances on that edge. MW loads the completed instruction; dm_req <= 0; state IDLE.
- dm_ack received while in IDLE (late or spurious) is ignored.
- MW_WBData selection, in priority order:
  - EM_MemtoReg = 1: dm_rdata, captured on the ack edge.
  - EM_RegDst = 2'h2: EM_PCPlus4.
  - Otherwise: EM_ALUResult.
- MW_RegWrite <= EM_RegWrite and MW_WBAddr <= EM_WBAddr on every completing edge.
- Latency:
  - Non-memory instruction: 1 cycle (EM to MW).
  - Memory instruction: 1 IDLE cycle + N BUSY cycles; minimum 2 cycles when dm_ack arrives in the first BUSY cycle.
- Back-to-back accesses: the new instruction is in EM on the cycle after ack. It sees IDLE and issues again, so dm_req is low for at least 1 cycle between accesses.
- Reset during BUSY: next cycle dm_req = 0 and state IDLE. No MW write occurs for the aborted access.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On reaching TIMEOUT_CYCLES, the access completes as if acked with dm_rdata = 32'h0: dm_req <= 0, stall released, MW loaded, MEM_Err <= 1.
  - MEM_Err stays set until rst.
- Undefined: no counter; BUSY waits indefinitely for dm_ack; MEM_Err is tied to 0.

Test Plan:
- ALU op (EM_RegWrite = 1, EM_WBAddr = 5'd8, EM_ALUResult = 32'h1234): no stall; next cycle MW_RegWrite = 1, MW_WBAddr = 8, MW_WBData = 32'h1234.
- Load (EM_ALUResult = 32'h103, EM_MemtoReg = 1, EM_WBAddr = 9), ack after 3 BUSY cycles with dm_rdata = 32'hCAFEF00D:
  - dm_addr = 32'h100, dm_we = 0.
  - MEM_Stall high for 4 cycles, low on the ack cycle.
  - MW_WBData = 32'hCAFEF00D, MW_RegWrite = 1 for exactly 1 cycle.
- Store (addr 32'h40, data 32'h55) immediately followed by a load: dm_we = 1, dm_wdata = 32'h55; dm_req drops for 1 cycle, then reissues with dm_we = 0.
- jal (EM_RegDst = 2'h2, EM_PCPlus4 = 32'h0040_0008, EM_WBAddr = 31): MW_WBData = 32'h0040_0008, no memory request.
- rst asserted in BUSY before ack: next cycle dm_req = 0, MEM_Stall = 0, MW_RegWrite = 0. A subsequent stray dm_ack causes no write.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, load with no ack: after 4 BUSY cycles, stall released, MW_WBData = 0, MEM_Err = 1 until rst.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// Data-memory request/acknowledge bus between mem_wb_stage (master) and the data memory (slave).
interface mem_wb_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
   modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: variable-latency data-memory handshake, upstream stall and write-back register.
// Optional access timeout with sticky MEM_Err is built in when MEM_TIMEOUT_EN is defined.
module mem_wb_stage #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               EM_MemRead,
   input  logic               EM_MemWrite,
   input  logic               EM_RegWrite,
   input  logic               EM_MemtoReg,
   input  logic [1:0]         EM_RegDst,
   input  logic [4:0]         EM_WBAddr,
   input  logic [31:0]        EM_ALUResult,
   input  logic [31:0]        EM_WriteData,
   input  logic [31:0]        EM_PCPlus4,
   mem_wb_stage_if.master     dm,
   output logic               MEM_Stall,
   output logic               MW_RegWrite,
   output logic [4:0]         MW_WBAddr,
   output logic [31:0]        MW_WBData,
   output logic               MEM_Err
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t      state;
   state_t      state_next;
   logic        pending;
   logic        issue;
   logic        complete;
   logic        timed_out;
   logic [31:0] mem_data;
   logic [31:0] wb_data;

   assign pending = EM_MemRead | EM_MemWrite;

`ifdef MEM_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CW-1:0] wait_count;

   // wait_count holds the BUSY cycles already spent, so the last allowed cycle completes itself
   assign timed_out = (state == BUSY) && !dm.dm_ack && (wait_count == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_count <= '0;
         MEM_Err    <= 1'b0;
      end else begin
         if (issue)
            wait_count <= '0;
         else if (state == BUSY && !dm.dm_ack)
            wait_count <= wait_count + 1'b1;
         if (timed_out)
            MEM_Err <= 1'b1;
      end
   end
`else
   assign timed_out = 1'b0;
   // TIMEOUT_CYCLES is referenced so the parameter stays live in this build
   assign MEM_Err   = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

   always_comb begin
      state_next = state;
      MEM_Stall  = 1'b0;
      issue      = 1'b0;
      complete   = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               MEM_Stall  = 1'b1;
               issue      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (dm.dm_ack || timed_out) begin
               complete   = 1'b1;
               state_next = IDLE;
            end else begin
               MEM_Stall = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign mem_data = timed_out ? 32'h0 : dm.dm_rdata;
   assign wb_data  = EM_MemtoReg          ? mem_data   :
                     (EM_RegDst == 2'h2)  ? EM_PCPlus4 :
                                            EM_ALUResult;

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // The request fields are captured once at issue and held untouched for the whole BUSY phase
   always_ff @(posedge clk) begin
      if (rst) begin
         dm.dm_req   <= 1'b0;
         dm.dm_we    <= 1'b0;
         dm.dm_addr  <= 32'h0;
         dm.dm_wdata <= 32'h0;
         MW_RegWrite <= 1'b0;
         MW_WBAddr   <= 5'h0;
         MW_WBData   <= 32'h0;
      end else begin
         if (issue) begin
            dm.dm_req   <= 1'b1;
            dm.dm_we    <= EM_MemWrite;
            dm.dm_addr  <= {EM_ALUResult[31:2], 2'b00};
            dm.dm_wdata <= EM_WriteData;
         end else if (complete) begin
            dm.dm_req   <= 1'b0;
         end

         if (MEM_Stall) begin
            MW_RegWrite <= 1'b0;
         end else begin
            MW_RegWrite <= EM_RegWrite;
            MW_WBAddr   <= EM_WBAddr;
            MW_WBData   <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised self-checking bench for mem_wb_stage against an instruction-level reference model.
// Timeout scenario is exercised when MEM_TIMEOUT_EN is defined.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        emMemRead, emMemWrite, emRegWrite, emMemtoReg;
   logic [1:0]  emRegDst;
   logic [4:0]  emWBAddr;
   logic [31:0] emALUResult, emWriteData, emPCPlus4;
   logic        memStall, mwRegWrite, memErr;
   logic [4:0]  mwWBAddr;
   logic [31:0] mwWBData;

   int assertCount = 0;
   int failCount   = 0;

   mem_wb_stage_if dmBus ();

   mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .EM_MemRead   (emMemRead),
      .EM_MemWrite  (emMemWrite),
      .EM_RegWrite  (emRegWrite),
      .EM_MemtoReg  (emMemtoReg),
      .EM_RegDst    (emRegDst),
      .EM_WBAddr    (emWBAddr),
      .EM_ALUResult (emALUResult),
      .EM_WriteData (emWriteData),
      .EM_PCPlus4   (emPCPlus4),
      .dm           (dmBus.master),
      .MEM_Stall    (memStall),
      .MW_RegWrite  (mwRegWrite),
      .MW_WBAddr    (mwWBAddr),
      .MW_WBData    (mwWBData),
      .MEM_Err      (memErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic setNop();
      emMemRead   = 1'b0;
      emMemWrite  = 1'b0;
      emRegWrite  = 1'b0;
      emMemtoReg  = 1'b0;
      emRegDst    = 2'h0;
      emWBAddr    = 5'h0;
      emALUResult = 32'h0;
      emWriteData = 32'h0;
      emPCPlus4   = 32'h0;
   endtask

   // Presents one instruction in EM (called #1 after a rising edge) and walks it to write-back.
   // ackCycle = index of the BUSY cycle in which dm_ack is returned (1 = first BUSY cycle).
   task automatic applyStimulus(input logic rd, input logic wr, input logic rw, input logic mtr,
                                input logic [1:0] rdst, input logic [4:0] wa,
                                input logic [31:0] alu, input logic [31:0] wd,
                                input logic [31:0] pc4, input int ackCycle);
      logic [31:0] loadData;
      logic [31:0] expData;
      emMemRead   = rd;
      emMemWrite  = wr;
      emRegWrite  = rw;
      emMemtoReg  = mtr;
      emRegDst    = rdst;
      emWBAddr    = wa;
      emALUResult = alu;
      emWriteData = wd;
      emPCPlus4   = pc4;
      loadData    = $urandom;
      if (!(rd || wr)) begin
         @(negedge clk);
         checkOutput("stall_nonmem", memStall, 1'b0);
      end else begin
         @(negedge clk);
         checkOutput("stall_issue", memStall, 1'b1);
         checkOutput("req_gap", dmBus.dm_req, 1'b0);
         @(posedge clk); #1;
         for (int k = 1; k < ackCycle; k++) begin
            @(negedge clk);
            checkOutput("stall_busy", memStall, 1'b1);
            checkOutput("req_busy", dmBus.dm_req, 1'b1);
            checkOutput("we_busy", dmBus.dm_we, wr);
            checkOutput("addr_busy", dmBus.dm_addr, alu - (alu % 4));
            checkOutput("wdata_busy", dmBus.dm_wdata, wd);
            checkOutput("bubble", mwRegWrite, 1'b0);
            @(posedge clk); #1;
         end
         dmBus.dm_ack   = 1'b1;
         dmBus.dm_rdata = loadData;
         @(negedge clk);
         checkOutput("stall_ack", memStall, 1'b0);
         checkOutput("req_ack", dmBus.dm_req, 1'b1);
         checkOutput("we_ack", dmBus.dm_we, wr);
         checkOutput("addr_ack", dmBus.dm_addr, alu - (alu % 4));
      end
      if (mtr)
         expData = loadData;
      else if (rdst == 2'h2)
         expData = pc4;
      else
         expData = alu;
      @(posedge clk); #1;
      dmBus.dm_ack   = 1'b0;
      dmBus.dm_rdata = $urandom;
      checkOutput("mw_regwrite", mwRegWrite, rw);
      checkOutput("mw_wbaddr", mwWBAddr, wa);
      checkOutput("mw_wbdata", mwWBData, expData);
      checkOutput("req_done", dmBus.dm_req, 1'b0);
   endtask

   initial begin
      int kind;
      logic rd, wr;
      rst = 1'b1;
      dmBus.dm_ack   = 1'b0;
      dmBus.dm_rdata = 32'h0;
      setNop();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req", dmBus.dm_req, 1'b0);
      checkOutput("rst_we", dmBus.dm_we, 1'b0);
      checkOutput("rst_addr", dmBus.dm_addr, 32'h0);
      checkOutput("rst_regwrite", mwRegWrite, 1'b0);
      checkOutput("rst_wbdata", mwWBData, 32'h0);
      checkOutput("rst_err", memErr, 1'b0);
      rst = 1'b0;

      $display("[TB] directed sequences");
      applyStimulus(0, 0, 1, 0, 2'h0, 5'd8, 32'h1234, 32'h0, 32'h0, 1);
      dmBus.dm_rdata = 32'hCAFEF00D;
      applyStimulus(1, 0, 1, 1, 2'h0, 5'd9, 32'h103, 32'h0, 32'h0, 4);
      applyStimulus(0, 1, 0, 0, 2'h0, 5'd0, 32'h40, 32'h55, 32'h0, 1);
      applyStimulus(1, 0, 1, 1, 2'h0, 5'd3, 32'h44, 32'h0, 32'h0, 2);
      applyStimulus(0, 0, 1, 0, 2'h2, 5'd31, 32'h777, 32'h0, 32'h0040_0008, 1);
      applyStimulus(1, 1, 0, 0, 2'h0, 5'd4, 32'h8F, 32'h99, 32'h0, 1);

      // Reset while an access is outstanding, then a stray ack in IDLE
      emMemRead   = 1'b1;
      emMemtoReg  = 1'b1;
      emRegWrite  = 1'b1;
      emWBAddr    = 5'd12;
      emALUResult = 32'h200;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("pre_rst_req", dmBus.dm_req, 1'b1);
      rst = 1'b1;
      setNop();
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort_req", dmBus.dm_req, 1'b0);
      checkOutput("abort_stall", memStall, 1'b0);
      checkOutput("abort_regwrite", mwRegWrite, 1'b0);
      dmBus.dm_ack = 1'b1;
      @(posedge clk); #1;
      dmBus.dm_ack = 1'b0;
      checkOutput("stray_regwrite", mwRegWrite, 1'b0);
      checkOutput("stray_req", dmBus.dm_req, 1'b0);

      $display("[TB] random sequences");
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 4);
         rd = (kind == 1) || (kind == 3);
         wr = (kind == 2) || (kind == 3);
         applyStimulus(rd, wr, 1'($urandom), rd && !wr && 1'($urandom), 2'($urandom),
                       5'($urandom), $urandom, $urandom, $urandom,
`ifdef MEM_TIMEOUT_EN
                       $urandom_range(1, 3));
`else
                       $urandom_range(1, 6));
`endif
      end
      checkOutput("err_clear", memErr, 1'b0);

`ifdef MEM_TIMEOUT_EN
      $display("[TB] timeout sequence");
      emMemRead   = 1'b1;
      emMemWrite  = 1'b0;
      emMemtoReg  = 1'b1;
      emRegWrite  = 1'b1;
      emRegDst    = 2'h0;
      emWBAddr    = 5'd10;
      emALUResult = 32'h300;
      dmBus.dm_rdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      for (int k = 1; k < 4; k++) begin
         @(negedge clk);
         checkOutput("to_stall_busy", memStall, 1'b1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      checkOutput("to_stall_release", memStall, 1'b0);
      @(posedge clk); #1;
      checkOutput("to_req", dmBus.dm_req, 1'b0);
      checkOutput("to_regwrite", mwRegWrite, 1'b1);
      checkOutput("to_wbdata", mwWBData, 32'h0);
      checkOutput("to_err", memErr, 1'b1);
      applyStimulus(0, 0, 1, 0, 2'h0, 5'd2, 32'h5, 32'h0, 32'h0, 1);
      checkOutput("to_err_sticky", memErr, 1'b1);
      rst = 1'b1;
      setNop();
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("to_err_rst", memErr, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
